// File: rtl/phy_sched_pkg.sv
// Shared types and constants for the PHY word scheduler.
package phy_sched_pkg;

  localparam int WORD_W = 32;
  localparam logic [1:0] PHASE_LAST = 2'd3;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEFAULT = 32'hBCBC_BCBC;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

endpackage

// File: rtl/phy_word_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning
// cyclically from ptr_i+1, so the last winner has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  logic [ID_W:0] cand;

  // Walk offsets 1..NUM_REQ from the pointer; earliest hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found_o && req_i[cand[ID_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/phy_word_scheduler.sv
// Round-robin scheduler sharing one 32-to-8 byte serializer between
// NUM_REQ word requesters. Each word is held for four clk_4f cycles and
// the next word loads on the phase==3 edge, so back-to-back words have no gap.
// Optional build macro PHY_SCHED_IDLE_FILL_EN: keep the link busy with
// IDLE_WORD while enabled and no requester is waiting.
module phy_word_scheduler
  import phy_sched_pkg::*;
#(
  parameter int                NUM_REQ   = 4,
  parameter int                ID_W      = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic                      sched_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [WORD_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [WORD_W-1:0]         word_out,
  output logic                      word_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic [1:0]                phase,
  output logic [15:0]               words_sent
);

  sched_state_e        state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [1:0]          phase_q, phase_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;

  logic [WORD_W-1:0]   req_words [NUM_REQ];
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic                arb_point;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_words[gi] = req_data[gi*WORD_W +: WORD_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Decisions happen every edge while idle, otherwise only on the last byte.
  assign arb_point = (state_q == IDLE) || (phase_q == PHASE_LAST);

  // Next-state: hold the word mid-transfer, arbitrate at word boundaries.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    valid_d = valid_q;
    grant_d = grant_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    ptr_d   = ptr_q;
    if (arb_point) begin
      phase_d = '0;
      if (sched_en && pick_found) begin
        state_d         = SEND;
        word_d          = req_words[pick_idx];
        valid_d         = 1'b1;
        grant_d         = pick_idx;
        ptr_d           = pick_idx;
        ack_d[pick_idx] = 1'b1;
        cnt_d           = cnt_q + 16'd1;
      end
`ifdef PHY_SCHED_IDLE_FILL_EN
      else if (sched_en) begin
        // Fill word: keeps byte alignment, no ack, no count, pointer untouched.
        state_d = SEND;
        word_d  = IDLE_WORD;
        valid_d = 1'b1;
        grant_d = '0;
      end
`endif
      else begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    end else begin
      phase_d = phase_q + 2'd1;
    end
  end

  // State register; active-low synchronous reset drops any word in flight.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req_ack    = ack_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign grant_id   = grant_q;
  assign phase      = phase_q;
  assign words_sent = cnt_q;

endmodule

// File: tb/tb_phy_word_scheduler.sv
// Bench for phy_word_scheduler: driver issues directed words and queues the
// hand-computed grant order; a monitor pops and compares each presented word.
module tb_phy_word_scheduler;

  localparam int N = 4;
  localparam logic [31:0] FILL = 32'hBCBC_BCBC;

  typedef struct packed {
    logic [31:0] word;
    logic [1:0]  id;
  } exp_t;

  logic            clk_4f = 1'b0;
  logic            reset;
  logic            sched_en;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic [31:0]     word_out;
  logic            word_valid;
  logic [1:0]      grant_id;
  logic [1:0]      phase;
  logic [15:0]     words_sent;

  exp_t        exp_q[$];
  logic [31:0] nxt_word [N];
  bit          nxt_has  [N];
  int          err_cnt = 0;
  int          chk_cnt = 0;

  always #5 clk_4f = ~clk_4f;

  phy_word_scheduler #(
    .NUM_REQ   (N),
    .ID_W      (2),
    .IDLE_WORD (FILL)
  ) dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .sched_en   (sched_en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .word_out   (word_out),
    .word_valid (word_valid),
    .grant_id   (grant_id),
    .phase      (phase),
    .words_sent (words_sent)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle; requesters that saw an ack present their next word or drop valid.
  task automatic tick();
    @(negedge clk_4f);
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        if (nxt_has[i]) begin
          req_data[i*32 +: 32] = nxt_word[i];
          nxt_has[i] = 1'b0;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic issue(input int i, input logic [31:0] w);
    req_data[i*32 +: 32] = w;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_word(input logic [31:0] w, input int id);
    exp_q.push_back({w, 2'(id)});
  endtask

  task automatic settle();
    int n;
    sched_en = 1'b0;
    n = 0;
    while (word_valid && n < 8) begin
      tick();
      n++;
    end
    chk("settle_idle", 32'(word_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_word"},  word_out,         32'd0);
    chk({tag, "_grant"}, 32'(grant_id),    32'd0);
    chk({tag, "_phase"}, 32'(phase),       32'd0);
    chk({tag, "_count"}, 32'(words_sent),  32'd0);
    chk({tag, "_ack"},   32'(req_ack),     32'd0);
  endtask

  // Monitor: pop one expectation per new word, check the word stays put.
  initial begin
    logic [31:0] held;
    logic [1:0]  ph_exp;
    logic [N-1:0] onehot;
    exp_t e;
    held   = '0;
    ph_exp = '0;
    forever begin
      @(negedge clk_4f);
      if (word_valid) begin
        if (phase == 2'd0) begin
          held   = word_out;
          ph_exp = 2'd1;
`ifdef PHY_SCHED_IDLE_FILL_EN
          if (word_out == FILL && req_ack == '0 && grant_id == 2'd0) begin
            $display("fill word data=%08h", word_out);
          end else
`endif
          if (exp_q.size() == 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL unexpected_word: got %h grant %0d expected none", word_out, grant_id);
          end else begin
            e = exp_q.pop_front();
            onehot = '0;
            onehot[e.id] = 1'b1;
            $display("word grant=%0d data=%08h", grant_id, word_out);
            chk("sb_word",  word_out,        e.word);
            chk("sb_grant", 32'(grant_id),   32'(e.id));
            chk("sb_ack",   32'(req_ack),    32'(onehot));
          end
        end else begin
          chk("hold_phase", 32'(phase),   32'(ph_exp));
          chk("hold_word",  word_out,     held);
          chk("hold_ack",   32'(req_ack), 32'd0);
          ph_exp = ph_exp + 2'd1;
        end
      end
    end
  end

  // Driver: directed scenarios.
  initial begin
    reset     = 1'b0;
    sched_en  = 1'b0;
    req_valid = '1;
    req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int i = 0; i < N; i++) begin
      nxt_has[i]  = 1'b0;
      nxt_word[i] = '0;
    end

    // Reset held with all requesters valid.
    repeat (3) tick();
    chk_all_zero("reset");

    // Round robin: all four hold valid and repop once; grants 0,1,2,3,0,1,2,3.
    req_valid = '0;
    reset     = 1'b1;
    sched_en  = 1'b1;
    for (int i = 0; i < N; i++) begin
      issue(i, 32'hA000_0000 | 32'(i));
      nxt_word[i] = 32'hB000_0000 | 32'(i);
      nxt_has[i]  = 1'b1;
    end
    for (int i = 0; i < N; i++) expect_word(32'hA000_0000 | 32'(i), i);
    for (int i = 0; i < N; i++) expect_word(32'hB000_0000 | 32'(i), i);
    for (int t = 0; t < 32; t++) begin
      tick();
      chk("rr_valid", 32'(word_valid), 32'd1);
    end
    chk("rr_count", 32'(words_sent), 32'd8);
    settle();

    // Single request on requester 2.
    sched_en = 1'b1;
    issue(2, 32'hA1B2_C3D4);
    expect_word(32'hA1B2_C3D4, 2);
    repeat (5) tick();
    chk("single_count", 32'(words_sent), 32'd9);
`ifndef PHY_SCHED_IDLE_FILL_EN
    chk("single_idle", 32'(word_valid), 32'd0);
`endif
    settle();

    // sched_en dropped at phase 1: word completes, nothing new is granted.
    sched_en = 1'b1;
    issue(1, 32'hD15A_B1ED);
    expect_word(32'hD15A_B1ED, 1);
    tick();
    tick();
    chk("dis_phase1", 32'(phase), 32'd1);
    sched_en = 1'b0;
    issue(0, 32'h0BAD_0BAD);
    tick();
    chk("dis_valid2", 32'(word_valid), 32'd1);
    chk("dis_phase2", 32'(phase), 32'd2);
    tick();
    chk("dis_valid3", 32'(word_valid), 32'd1);
    chk("dis_phase3", 32'(phase), 32'd3);
    tick();
    chk("dis_idle",  32'(word_valid), 32'd0);
    chk("dis_ack",   32'(req_ack),    32'd0);
    chk("dis_count", 32'(words_sent), 32'd10);
    req_valid[0] = 1'b0;

    // Reset asserted at phase 2.
    sched_en = 1'b1;
    issue(2, 32'h5EED_F00D);
    expect_word(32'h5EED_F00D, 2);
    tick();
    tick();
    tick();
    chk("rst_mid_phase", 32'(phase), 32'd2);
    reset = 1'b0;
    tick();
    chk_all_zero("rst_mid");

    // After reset requester 0 wins first even with requester 3 also waiting.
    reset    = 1'b1;
    sched_en = 1'b1;
    issue(3, 32'h3030_3030);
    issue(0, 32'h0000_0F0F);
    expect_word(32'h0000_0F0F, 0);
    expect_word(32'h3030_3030, 3);
    repeat (8) tick();
    chk("ptr_count", 32'(words_sent), 32'd2);
    settle();

`ifdef PHY_SCHED_IDLE_FILL_EN
    // Idle fill, then a request at phase 1 granted on the next phase==3 edge.
    begin
      int n;
      sched_en = 1'b1;
      tick();
      chk("fill_valid", 32'(word_valid), 32'd1);
      chk("fill_word",  word_out,        FILL);
      chk("fill_ack",   32'(req_ack),    32'd0);
      n = 0;
      while (phase != 2'd1 && n < 8) begin
        tick();
        n++;
      end
      chk("fill_sync", 32'(phase), 32'd1);
      issue(1, 32'h1234_5678);
      expect_word(32'h1234_5678, 1);
      tick();
      chk("fill_wait_word", word_out, FILL);
      tick();
      chk("fill_wait_phase", 32'(phase), 32'd3);
      tick();
      chk("fill_grant", 32'(grant_id), 32'd1);
      chk("fill_req_word", word_out, 32'h1234_5678);
      chk("fill_count", 32'(words_sent), 32'd3);
      repeat (3) tick();
      settle();
    end
`endif

    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
